selector_corriente: RTL

- Upstream stage of the current-lookup memory. Turns two raw pushbuttons (up/down) into the 4-bit current selection code 0..10 that the lookup memory consumes on its `corriente` input.
- Synchronizes and debounces the buttons, then steps a saturating selection register.
- Flags each change with a one-cycle pulse and reports the limit flags.

---
 rtl/selector_corriente.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/selector_corriente.sv
// selector_corriente: synchronized, debounced up/down pushbuttons step a saturating 0..MAX_SEL code.
// Optional hold-to-repeat stepping is compiled in by defining SEL_AUTOREPEAT_EN.
module selector_corriente #(
  parameter int DEB_CNT = 50000,
  parameter int MAX_SEL = 10
`ifdef SEL_AUTOREPEAT_EN
  ,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] corriente,
  output logic       cambio,
  output logic       en_min,
  output logic       en_max
);

  localparam logic [15:0] DEB_LAST = 16'(DEB_CNT - 1);
  localparam logic [3:0]  SEL_MAX  = 4'(MAX_SEL);

`ifdef SEL_AUTOREPEAT_EN
  localparam logic [31:0] DELAY_LAST  = 32'(REP_DELAY - 1);
  localparam logic [31:0] PERIOD_LAST = 32'(REP_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
`else
  typedef enum logic {IDLE, HELD} state_t;
`endif

  // Bit 0 is the up button, bit 1 the down button.
  logic [1:0] raw;
  logic [1:0] press;
  logic [1:0] rep;
  logic [1:0] req_reg;

  assign raw = {btn_down, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic        sync1_reg;
      logic        s_reg;
      logic        db_reg;
      logic        db_q_reg;
      logic        armed_reg;
      logic [15:0] cnt_reg;
      logic        eff;
      state_t      state_reg;

      // Until a clean release has been debounced the button is treated as held,
      // so a button kept pressed through reset cannot produce a press event.
      assign eff = armed_reg ? db_reg : 1'b1;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          s_reg     <= 1'b0;
          db_reg    <= 1'b0;
          db_q_reg  <= 1'b0;
          armed_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw[gi];
          s_reg     <= sync1_reg;
          db_q_reg  <= db_reg;
          if (s_reg == eff) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            cnt_reg <= '0;
            if (armed_reg) begin
              db_reg <= s_reg;
            end else begin
              armed_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
      end

      assign press[gi] = db_reg & ~db_q_reg;

`ifdef SEL_AUTOREPEAT_EN
      logic [31:0] hold_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= IDLE;
          hold_reg  <= '0;
        end else begin
          case (state_reg)
            IDLE: begin
              hold_reg <= '0;
              if (press[gi]) state_reg <= HELD;
            end
            HELD: begin
              if (!db_reg) begin
                state_reg <= IDLE;
                hold_reg  <= '0;
              end else if (hold_reg == DELAY_LAST) begin
                state_reg <= REPEAT;
                hold_reg  <= '0;
              end else begin
                hold_reg <= hold_reg + 32'd1;
              end
            end
            REPEAT: begin
              if (!db_reg) begin
                state_reg <= IDLE;
                hold_reg  <= '0;
              end else if (hold_reg == PERIOD_LAST) begin
                hold_reg <= '0;
              end else begin
                hold_reg <= hold_reg + 32'd1;
              end
            end
            default: begin
              state_reg <= IDLE;
              hold_reg  <= '0;
            end
          endcase
        end
      end

      assign rep[gi] = (state_reg == REPEAT) && db_reg && (hold_reg == PERIOD_LAST);
`else
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= IDLE;
        end else begin
          case (state_reg)
            IDLE:    if (press[gi]) state_reg <= HELD;
            HELD:    if (!db_reg) state_reg <= IDLE;
            default: state_reg <= IDLE;
          endcase
        end
      end

      assign rep[gi] = 1'b0;
`endif
    end
  endgenerate

  // Step requests are registered once, so both directions in the same cycle cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_reg   <= 2'b00;
      corriente <= '0;
      cambio    <= 1'b0;
      en_min    <= 1'b1;
      en_max    <= 1'b0;
    end else begin
      req_reg <= press | rep;
      cambio  <= 1'b0;
      if (req_reg == 2'b01 && corriente != SEL_MAX) begin
        corriente <= corriente + 4'd1;
        cambio    <= 1'b1;
        en_min    <= 1'b0;
        en_max    <= (corriente + 4'd1 == SEL_MAX);
      end else if (req_reg == 2'b10 && corriente != 4'd0) begin
        corriente <= corriente - 4'd1;
        cambio    <= 1'b1;
        en_min    <= (corriente == 4'd1);
        en_max    <= 1'b0;
      end
    end
  end

endmodule
